// File: rtl/inst_mem_responder.sv
// AXI4 read-only slave serving instruction-fetch bursts from a word-addressed RAM.
// A side load port writes program words with byte enables at any time, including during reset.
module inst_mem_responder #(
    parameter int C_S_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_S_AXI_ADDR_WIDTH      = 32,
    parameter int C_S_AXI_DATA_WIDTH      = 32,
    parameter int C_MEM_DEPTH_LOG2        = 12,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [7:0]                         S_AXI_ARLEN,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RLAST,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    input  logic                               LOAD_EN,
    input  logic [C_MEM_DEPTH_LOG2-1:0]        LOAD_ADDR,
    input  logic [31:0]                        LOAD_DATA,
    input  logic [3:0]                         LOAD_STRB
);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DEPTH = 1 << C_MEM_DEPTH_LOG2;
    // Memory size in bytes, one bit wider than the address so the compare is exact.
    localparam logic [AW:0] MEM_BYTES =
        {{(AW - C_MEM_DEPTH_LOG2 - 2){1'b0}}, 1'b1, {(C_MEM_DEPTH_LOG2 + 2){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t                             state, state_n;
    logic [AW-1:0]                      addr, addr_n;
    logic [8:0]                         remaining, remaining_n;
    logic                               ar_ready, ar_ready_n;
    logic                               rvalid, rvalid_n;
    logic                               rlast, rlast_n;
    logic [1:0]                         rresp, rresp_n;
    logic [C_S_AXI_THREAD_ID_WIDTH-1:0] rid, rid_n;
    logic [C_S_AXI_DATA_WIDTH-1:0]      rdata;

    logic [31:0]                 mem [0:DEPTH-1];
    logic [AW-1:0]               offset;
    logic                        in_range;
    logic [C_MEM_DEPTH_LOG2-1:0] word_idx;

    // Unsigned offset: addresses below the base wrap to huge values and fail the check.
    assign offset   = addr - C_BASE_ADDR;
    assign in_range = {1'b0, offset} < MEM_BYTES;
    assign word_idx = offset[C_MEM_DEPTH_LOG2+1:2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            ar_ready  <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rresp     <= 2'b00;
            rid       <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            ar_ready  <= ar_ready_n;
            rvalid    <= rvalid_n;
            rlast     <= rlast_n;
            rresp     <= rresp_n;
            rid       <= rid_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        ar_ready_n  = ar_ready;
        rvalid_n    = rvalid;
        rlast_n     = rlast;
        rresp_n     = rresp;
        rid_n       = rid;
        case (state)
            IDLE: begin
                ar_ready_n = 1'b1;
                if (S_AXI_ARVALID && ar_ready) begin
                    state_n     = FETCH;
                    ar_ready_n  = 1'b0;
                    rid_n       = S_AXI_ARID;
                    remaining_n = {1'b0, S_AXI_ARLEN} + 9'd1;
                    addr_n      = S_AXI_ARADDR & ~AW'(3);
                end
            end
            FETCH: begin
                state_n  = SEND;
                rvalid_n = 1'b1;
                rlast_n  = (remaining == 9'd1);
                rresp_n  = in_range ? 2'b00 : 2'b10;
            end
            SEND: begin
                if (S_AXI_RREADY) begin
                    rvalid_n = 1'b0;
                    if (rlast) begin
                        rlast_n    = 1'b0;
                        ar_ready_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        remaining_n = remaining - 9'd1;
                        addr_n      = addr + AW'(4);
                        state_n     = FETCH;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Synchronous RAM read with enable; the load write below lands on the same edge,
    // so a same-cycle fetch of that word sees the old contents.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata <= '0;
        end else if (state == FETCH) begin
            rdata <= in_range ? mem[word_idx] : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (LOAD_EN) begin
            for (int b = 0; b < 4; b++) begin
                if (LOAD_STRB[b]) begin
                    mem[LOAD_ADDR][8*b +: 8] <= LOAD_DATA[8*b +: 8];
                end
            end
        end
    end

    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RID     = rid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RLAST   = rlast;
    assign S_AXI_RVALID  = rvalid;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: directed program-fetch scenarios followed by random bursts,
// each beat checked against a word-array model of the RAM and the address-range rule.
module tb_inst_mem_responder;
    localparam int          DEPTH_LOG2 = 12;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam logic [31:0] MEM_BYTES  = 32'd4 * DEPTH;

    logic        CLK = 1'b0;
    logic        RST;
    logic [0:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        LOAD_EN;
    logic [11:0] LOAD_ADDR;
    logic [31:0] LOAD_DATA;
    logic [3:0]  LOAD_STRB;

    inst_mem_responder dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA), .LOAD_STRB(LOAD_STRB)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model and scoreboard: {rresp, rlast, rdata}
    logic [31:0] model_mem [0:DEPTH-1];
    logic [34:0] exp_q [$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [31:0] addr, input int len);
        for (int k = 0; k <= len; k++) begin
            logic [31:0] a;
            logic [31:0] off;
            logic        last;
            a    = (addr & 32'hFFFF_FFFC) + 32'(4 * k);
            off  = a - BASE;
            last = (k == len);
            if (off < MEM_BYTES) exp_q.push_back({2'b00, last, model_mem[off / 4]});
            else                 exp_q.push_back({2'b10, last, 32'h0});
        end
    endtask

    // Drivers
    task automatic load_word(input int idx, input logic [31:0] data, input logic [3:0] strb);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 12'(idx);
        LOAD_DATA = data;
        LOAD_STRB = strb;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        tick();
        LOAD_EN = 1'b0;
    endtask

    // Presents AR and returns right after the handshake edge.
    task automatic ar_issue(input logic [31:0] addr, input int len, input logic id, output bit ok);
        int w;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = 8'(len);
        S_AXI_ARID    = id;
        S_AXI_ARVALID = 1'b1;
        w = 0;
        while (!S_AXI_ARREADY && w < 20) begin
            tick();
            w++;
        end
        ok = S_AXI_ARREADY;
        if (!ok) check("arready_timeout", 64'(S_AXI_ARREADY), 64'(1));
        else     tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_ARADDR  = $urandom;
        S_AXI_ARLEN   = 8'($urandom);
    endtask

    // Waits for one beat (expected exactly one cycle after the previous edge of interest).
    task automatic wait_beat(input string tag);
        int w;
        w = 0;
        while (!S_AXI_RVALID && w < 8) begin
            tick();
            w++;
        end
        check({tag, "_latency"}, 64'(w), 64'(1));
    endtask

    task automatic run_burst(input logic [31:0] addr, input int len, input logic id,
                             input int stall_beat, input int stall_len);
        bit          ok;
        logic [34:0] e;
        logic [31:0] held;
        push_expected(addr, len);
        S_AXI_RREADY = 1'b1;
        ar_issue(addr, len, id, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        for (int k = 0; k <= len; k++) begin
            wait_beat("beat");
            e = exp_q.pop_front();
            check("rvalid", 64'(S_AXI_RVALID), 64'(1));
            check("rdata",  64'(S_AXI_RDATA),  64'(e[31:0]));
            check("rlast",  64'(S_AXI_RLAST),  64'(e[32]));
            check("rresp",  64'(S_AXI_RRESP),  64'(e[34:33]));
            check("rid",    64'(S_AXI_RID),    64'(id));
            check("arready_busy", 64'(S_AXI_ARREADY), 64'(0));
            if (k == stall_beat) begin
                held = S_AXI_RDATA;
                S_AXI_RREADY = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check("stall_rvalid", 64'(S_AXI_RVALID), 64'(1));
                    check("stall_rdata",  64'(S_AXI_RDATA),  64'(held));
                end
                S_AXI_RREADY = 1'b1;
            end
            tick();
        end
        check("end_rvalid",  64'(S_AXI_RVALID),  64'(0));
        check("end_arready", 64'(S_AXI_ARREADY), 64'(1));
    endtask

    // Directed steps, then random bursts
    initial begin
        bit          ok;
        logic [31:0] a;
        int          len, sb, sl;

        RST = 1'b1;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        LOAD_EN = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0; LOAD_STRB = '0;
        tick();
        check("rst_arready", 64'(S_AXI_ARREADY), 64'(0));
        check("rst_rvalid",  64'(S_AXI_RVALID),  64'(0));
        check("rst_rlast",   64'(S_AXI_RLAST),   64'(0));
        check("rst_rdata",   64'(S_AXI_RDATA),   64'(0));
        check("rst_rresp",   64'(S_AXI_RRESP),   64'(0));
        check("rst_rid",     64'(S_AXI_RID),     64'(0));

        // Whole RAM filled while still in reset.
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom, 4'hF);
        RST = 1'b0;
        tick();
        check("post_rst_arready", 64'(S_AXI_ARREADY), 64'(1));

        load_word(0, 32'h0000_0013, 4'hF);
        load_word(1, 32'h0010_0093, 4'hF);
        load_word(2, 32'h0020_0113, 4'hF);
        load_word(3, 32'h0030_0193, 4'hF);

        run_burst(32'h0, 0, 1'b1, -1, 0);
        run_burst(32'h4, 2, 1'b0, -1, 0);
        run_burst(32'h4, 2, 1'b1, 1, 5);
        run_burst(32'h4000, 0, 1'b0, -1, 0);
        run_burst(32'h3FFC, 1, 1'b1, -1, 0);
        run_burst(32'h0000_3FFE, 0, 1'b0, -1, 0);

        // Reset during beat 1 of a 4-beat burst.
        S_AXI_RREADY = 1'b1;
        ar_issue(32'h0, 3, 1'b1, ok);
        wait_beat("rstb0");
        check("rstb0_rdata", 64'(S_AXI_RDATA), 64'(32'h0000_0013));
        tick();
        wait_beat("rstb1");
        check("rstb1_rdata", 64'(S_AXI_RDATA), 64'(32'h0010_0093));
        RST = 1'b1;
        tick();
        check("midrst_rvalid",  64'(S_AXI_RVALID),  64'(0));
        check("midrst_rlast",   64'(S_AXI_RLAST),   64'(0));
        check("midrst_rdata",   64'(S_AXI_RDATA),   64'(0));
        check("midrst_rid",     64'(S_AXI_RID),     64'(0));
        check("midrst_arready", 64'(S_AXI_ARREADY), 64'(0));
        RST = 1'b0;
        tick();
        check("midrst_arready_back", 64'(S_AXI_ARREADY), 64'(1));
        run_burst(32'h0, 0, 1'b0, -1, 0);

        // Load collides with FETCH of the same word: old data is returned.
        S_AXI_RREADY = 1'b1;
        ar_issue(32'h0, 0, 1'b1, ok);
        LOAD_EN = 1'b1; LOAD_ADDR = 12'd0; LOAD_DATA = 32'hDEAD_BEEF; LOAD_STRB = 4'hF;
        tick();
        LOAD_EN = 1'b0;
        model_mem[0] = 32'hDEAD_BEEF;
        check("readfirst_rvalid", 64'(S_AXI_RVALID), 64'(1));
        check("readfirst_rdata",  64'(S_AXI_RDATA),  64'(32'h0000_0013));
        tick();
        run_burst(32'h0, 0, 1'b0, -1, 0);
        load_word(0, 32'h0000_00AA, 4'b0001);
        run_burst(32'h0, 0, 1'b1, -1, 0);
        check("strb_model", 64'(model_mem[0]), 64'(32'hDEAD_BEAA));

        // Maximum-length burst from a random aligned start.
        run_burst(BASE + 32'($urandom_range(0, DEPTH - 1)) * 4, 255, 1'b1, -1, 0);

        for (int it = 0; it < 40; it++) begin
            for (int l = 0; l < $urandom_range(0, 2); l++)
                load_word($urandom_range(0, DEPTH - 1), $urandom, 4'($urandom));
            case ($urandom_range(0, 9))
                0, 1:    a = BASE + MEM_BYTES - 32'($urandom_range(0, 40));
                2:       a = $urandom;
                3:       a = BASE - 32'($urandom_range(1, 16));
                default: a = BASE + 32'($urandom_range(0, MEM_BYTES - 1));
            endcase
            len = $urandom_range(0, 15);
            sb  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len) : -1;
            sl  = $urandom_range(1, 4);
            run_burst(a, len, 1'($urandom_range(0, 1)), sb, sl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
